tiny16_dma: RTL and testbench
=============================

TINY16_DMA -- requirements
Module: tiny16_dma

Interface
REQ-001 Parameter: LEN_BITS, 16, width of transfer-length register.
REQ-002 Parameter: TIMEOUT_BITS, 8, width of per-request bus-timeout counter; timeout = 2**TIMEOUT_BITS-1 cycles.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 nreset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin transfer; sampled only in IDLE.
REQ-006 src  in  16  source word address, captured on accepted start.
REQ-007 dst  in  16  destination word address, captured on accepted start.
REQ-008 len  in  LEN_BITS  word count, captured on accepted start.
REQ-009 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-010 error  out  1  high after bus timeout; cleared by next accepted start or reset.
REQ-011 interrupt  out  1  level completion/error flag.
REQ-012 in_interrupt  in  1  acknowledge; clears interrupt.
REQ-013 address  out  16  bus address.
REQ-014 data_out  out  16  bus write data.
REQ-015 data_in  in  16  bus read data.
REQ-016 nwr  out  1  bus direction, 0 = write, 1 = read.
REQ-017 mem_valid  out  1  bus request.
REQ-018 mem_ready  in  1  responder completion.

Function
REQ-019 States SHALL be IDLE, READ, RGAP, WRITE, WGAP, ERROR.
REQ-020 IDLE + start: capture src/dst/len, clear error; len==0 -> stay IDLE, set interrupt, no bus cycle; else -> READ.
REQ-021 READ: mem_valid=1, nwr=1, address=src; at posedge with mem_ready=1 latch data_in into word buffer, -> RGAP.
REQ-022 RGAP: mem_valid=0 for exactly one cycle, -> WRITE.
REQ-023 WRITE: mem_valid=1, nwr=0, address=dst, data_out=word buffer; at posedge with mem_ready=1 -> WGAP.
REQ-024 WGAP: mem_valid=0; src+1, dst+1, remaining-1; remaining becomes 0 -> IDLE and set interrupt, else -> READ.
REQ-025 address, nwr, data_out SHALL be stable while mem_valid=1; mem_ready ignored while mem_valid=0.
REQ-026 Each word costs 4 cycles minimum with a zero-wait responder (mem_ready one cycle after mem_valid: 6 cycles).
REQ-027 Address increment SHALL wrap 16'hFFFF -> 16'h0000 modulo 2**16.
REQ-028 Timeout counter SHALL clear on entering READ/WRITE, increment each cycle mem_valid=1 without mem_ready; reaching all-ones -> ERROR.
REQ-029 ERROR: mem_valid=0, error=1, interrupt set, -> IDLE next cycle.
REQ-030 start while not IDLE SHALL be ignored.
REQ-031 Set and in_interrupt in same cycle: set wins.
REQ-032 busy SHALL be low in IDLE and ERROR-to-IDLE cycle onward.

Reset
REQ-033 nreset=0 at posedge: state IDLE, mem_valid=0, nwr=1, address=0, data_out=0, busy=0, error=0, interrupt=0, counters 0.
REQ-034 Reset mid-transfer SHALL drop mem_valid in the following cycle; no further bus cycles.

Configuration
REQ-035 Macro TINY16_DMA_FILL_EN defined: start with src[15]=1 selects fill mode -- READ/RGAP skipped, each WRITE stores {1'b0, src[14:0]} to successive dst; src not incremented.
REQ-036 Macro undefined: src[15] is an ordinary address bit; copy mode only.

Structure
REQ-037 Shared package tiny16_pkg SHALL hold the state enum and bus-width constants (16-bit address/data).
REQ-038 Sub-module tiny16_bus_timer (timeout counter, clear/expire) is natural; everything else in one module.

Verification
REQ-039 Copy: src=0x0100, dst=0x0200, len=3, zero-wait responder -> three read/write pairs, memory 0x0200..0x0202 equals source, interrupt=1, busy low after 18 cycles.
REQ-040 len=0 start -> no mem_valid pulse, interrupt=1 next cycle, busy stays 0.
REQ-041 Wrap: src=0xFFFF, dst=0x7FFF, len=2 -> reads 0xFFFF then 0x0000, writes 0x7FFF then 0x8000.
REQ-042 Responder never asserts mem_ready, TIMEOUT_BITS=4 -> mem_valid drops after 15 cycles, error=1, interrupt=1, state IDLE.
REQ-043 nreset low during second WRITE of len=4 -> next cycle mem_valid=0, busy=0; in_interrupt with completion set same cycle -> interrupt stays 1.
REQ-044 TINY16_DMA_FILL_EN: src=0x8055, dst=0x0010, len=2 -> only write cycles, 0x0010 and 0x0011 hold 0x0055.

Source files
------------

// File: rtl/tiny16_pkg.sv
// rtl/tiny16_pkg.sv - shared state encoding and bus widths for tiny16_dma
package tiny16_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RGAP,
        WRITE,
        WGAP,
        ERROR
    } state_t;
endpackage

// File: rtl/tiny16_bus_timer.sv
// rtl/tiny16_bus_timer.sv - per-request bus timeout; expires after 2**TIMEOUT_BITS-1 waiting cycles
module tiny16_bus_timer #(
    parameter int TIMEOUT_BITS = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic run,
    output logic expire
);
    localparam logic [TIMEOUT_BITS-1:0] EXPIRE_AT = {TIMEOUT_BITS{1'b1}} - TIMEOUT_BITS'(1);

    logic [TIMEOUT_BITS-1:0] count;

    // Held at zero whenever no request is waiting, so every READ/WRITE starts from zero.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    assign expire = run && (count == EXPIRE_AT);
endmodule

// File: rtl/tiny16_dma.sv
// rtl/tiny16_dma.sv - single-channel word copy DMA; TINY16_DMA_FILL_EN adds constant-fill mode
module tiny16_dma
    import tiny16_pkg::*;
#(
    parameter int LEN_BITS     = 16,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src,
    input  logic [ADDR_W-1:0]   dst,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    output logic                error,
    output logic                interrupt,
    input  logic                in_interrupt,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   data_out,
    input  logic [DATA_W-1:0]   data_in,
    output logic                nwr,
    output logic                mem_valid,
    input  logic                mem_ready
);
    state_t              state, state_d;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [LEN_BITS-1:0] rem_q;
    logic [DATA_W-1:0]   word_q;
    logic                irq_set;
    logic                expire;
    logic                accept;
    logic                fill_start;
    logic                fill_q;

    assign accept = (state == IDLE) && start;

`ifdef TINY16_DMA_FILL_EN
    assign fill_start = src[15];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            fill_q <= 1'b0;
        end else if (accept) begin
            fill_q <= src[15];
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_q     = 1'b0;
`endif

    tiny16_bus_timer #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_timer (
        .clk    (clk),
        .nreset (nreset),
        .run    (mem_valid && !mem_ready),
        .expire (expire)
    );

    always_comb begin
        state_d = state;
        irq_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        irq_set = 1'b1;
                    end else begin
                        state_d = fill_start ? WRITE : READ;
                    end
                end
            end
            READ: begin
                if (mem_ready) begin
                    state_d = RGAP;
                end else if (expire) begin
                    state_d = ERROR;
                    irq_set = 1'b1;
                end
            end
            RGAP: state_d = WRITE;
            WRITE: begin
                if (mem_ready) begin
                    state_d = WGAP;
                end else if (expire) begin
                    state_d = ERROR;
                    irq_set = 1'b1;
                end
            end
            WGAP: begin
                if (rem_q == LEN_BITS'(1)) begin
                    state_d = IDLE;
                    irq_set = 1'b1;
                end else begin
                    state_d = fill_q ? WRITE : READ;
                end
            end
            ERROR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            word_q    <= '0;
            error     <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                src_q <= src;
                dst_q <= dst;
                rem_q <= len;
                error <= 1'b0;
                // In fill mode the word buffer holds the constant for every write.
                if (fill_start) begin
                    word_q <= {1'b0, src[14:0]};
                end
            end
            if ((state == READ) && mem_ready) begin
                word_q <= data_in;
            end
            if (state == WGAP) begin
                if (!fill_q) begin
                    src_q <= src_q + 16'd1;
                end
                dst_q <= dst_q + 16'd1;
                rem_q <= rem_q - LEN_BITS'(1);
            end
            if (state_d == ERROR) begin
                error <= 1'b1;
            end
            if (irq_set) begin
                interrupt <= 1'b1;
            end else if (in_interrupt) begin
                interrupt <= 1'b0;
            end
        end
    end

    assign mem_valid = (state == READ) || (state == WRITE);
    assign nwr       = (state != WRITE);
    assign busy      = (state == READ) || (state == RGAP) || (state == WRITE) || (state == WGAP);
    assign address   = (state == READ) ? src_q : ((state == WRITE) ? dst_q : '0);
    assign data_out  = (state == WRITE) ? word_q : '0;
endmodule

// File: tb/tb_tiny16_dma.sv
// tb/tb_tiny16_dma.sv - scoreboard bench for tiny16_dma with a word-level transfer model
module tb_tiny16_dma;
    localparam int TB_TIMEOUT_BITS = 4;

    logic        clk = 1'b0;
    logic        nreset, start, in_interrupt, mem_ready;
    logic        busy, error, interrupt, nwr, mem_valid;
    logic [15:0] src, dst, len, address, data_out, data_in;

    always #5 clk = ~clk;

    tiny16_dma #(.LEN_BITS(16), .TIMEOUT_BITS(TB_TIMEOUT_BITS)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .start        (start),
        .src          (src),
        .dst          (dst),
        .len          (len),
        .busy         (busy),
        .error        (error),
        .interrupt    (interrupt),
        .in_interrupt (in_interrupt),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .nwr          (nwr),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    bit          hang = 1'b0;
    int          valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Word-level model: pushes the bus traffic a transfer must produce and returns its busy length.
    function automatic int model_xfer(input logic [15:0] s, input logic [15:0] d,
                                      input logic [15:0] l, input int wait_cycles);
        bit   fill;
        int   cyc;
        txn_t t;
        fill = 1'b0;
        cyc  = 0;
`ifdef TINY16_DMA_FILL_EN
        fill = s[15];
`endif
        for (int i = 0; i < int'(l); i++) begin
            logic [15:0] sa, da, w;
            sa = 16'(s + i);
            da = 16'(d + i);
            w  = fill ? {1'b0, s[14:0]} : ref_mem[sa];
            if (!fill) begin
                t = '{wr: 1'b0, addr: sa, data: 16'h0};
                exp_q.push_back(t);
            end
            t = '{wr: 1'b1, addr: da, data: w};
            exp_q.push_back(t);
            ref_mem[da] = w;
            cyc += fill ? (wait_cycles + 2) : (2 * wait_cycles + 4);
        end
        return cyc;
    endfunction

    initial begin : responder
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        data_in = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_valid && !hang) begin
                if (cnt >= lat) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (nwr) data_in = mem[address];
                    else mem[address] = data_out;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        txn_t e;
        forever begin
            @(negedge clk);
            if (mem_valid) valid_cycles++;
            if (nreset && mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bus_txn actual addr=%0h nwr=%0b required none", address, nwr);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_dir_write", {31'b0, !nwr}, {31'b0, e.wr});
                    check("bus_addr", {16'b0, address}, {16'b0, e.addr});
                    if (e.wr) check("bus_wdata", {16'b0, data_out}, {16'b0, e.data});
                end
            end
        end
    end

    task automatic clear_irq();
        @(negedge clk);
        in_interrupt = 1'b1;
        @(negedge clk);
        in_interrupt = 1'b0;
        check("irq_ack_clears", {31'b0, interrupt}, 32'd0);
    endtask

    task automatic run_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input int wait_cycles, input bit poke);
        int exp_cyc, n;
        lat = wait_cycles;
        exp_cyc = model_xfer(s, d, l, wait_cycles);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (!busy || n > 2000) break;
            if (poke && n == 3) begin
                start = 1'b1;
                src = 16'($urandom);
                dst = 16'($urandom);
                len = 16'($urandom_range(1, 9));
            end
            n++;
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, n, exp_cyc);
        check({tag, "_irq"}, {31'b0, interrupt}, 32'd1);
        check({tag, "_pending_txns"}, exp_q.size(), 32'd0);
    endtask

    initial begin : main
        int n, vc, wr_phases, mism;
        bit prev, cur;
        nreset = 1'b0; start = 1'b0; in_interrupt = 1'b0;
        src = 16'h0; dst = 16'h0; len = 16'h0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_nwr", {31'b0, nwr}, 32'd1);
        check("rst_address", {16'b0, address}, 32'd0);
        check("rst_data_out", {16'b0, data_out}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_irq", {31'b0, interrupt}, 32'd0);
        nreset = 1'b1;

        run_xfer("copy3", 16'h0100, 16'h0200, 16'd3, 1, 1'b0);
        for (int i = 0; i < 3; i++)
            check("copy3_mem", {16'b0, mem[16'h0200 + i]}, {16'b0, ref_mem[16'h0100 + i]});
        clear_irq();

        vc = valid_cycles;
        run_xfer("len0", 16'h1111, 16'h2222, 16'd0, 1, 1'b0);
        check("len0_no_bus", valid_cycles, vc);
        clear_irq();

        run_xfer("wrap", 16'hFFFF, 16'h7FFF, 16'd2, 1, 1'b0);
        clear_irq();

`ifdef TINY16_DMA_FILL_EN
        run_xfer("fill", 16'h8055, 16'h0010, 16'd2, 1, 1'b0);
        check("fill_w0", {16'b0, mem[16'h0010]}, 32'h0055);
        check("fill_w1", {16'b0, mem[16'h0011]}, 32'h0055);
        clear_irq();
`endif

        hang = 1'b1;
        @(negedge clk);
        src = 16'h1234; dst = 16'h4321; len = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mem_valid && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("timeout_valid_cycles", n, (1 << TB_TIMEOUT_BITS) - 1);
        check("timeout_error", {31'b0, error}, 32'd1);
        check("timeout_irq", {31'b0, interrupt}, 32'd1);
        check("timeout_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("timeout_idle_valid", {31'b0, mem_valid}, 32'd0);
        check("timeout_error_held", {31'b0, error}, 32'd1);
        hang = 1'b0;
        clear_irq();
        run_xfer("after_err", 16'h0400, 16'h0500, 16'd1, 2, 1'b0);
        check("error_cleared", {31'b0, error}, 32'd0);
        clear_irq();

        in_interrupt = 1'b1;
        run_xfer("set_wins", 16'h0600, 16'h0700, 16'd1, 1, 1'b0);
        @(negedge clk);
        check("ack_after_set", {31'b0, interrupt}, 32'd0);
        in_interrupt = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_xfer("rand", 16'($urandom), 16'($urandom), 16'($urandom_range(1, 6)),
                     int'($urandom_range(1, 3)), 1'b1);
            clear_irq();
        end

        lat = 1;
        void'(model_xfer(16'h3000, 16'h3000, 16'd4, 1));
        @(negedge clk);
        src = 16'h3000; dst = 16'h3000; len = 16'd4; start = 1'b1;
        n = 0; wr_phases = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            n++;
            cur = mem_valid && !nwr;
            if (cur && !prev) wr_phases++;
            prev = cur;
            if (wr_phases == 2 || n > 200) break;
        end
        check("rst_mid_reached_write2", wr_phases, 2);
        nreset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_irq", {31'b0, interrupt}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        exp_q.delete();
        vc = valid_cycles;
        repeat (5) @(negedge clk);
        check("rst_mid_no_bus", valid_cycles, vc);

        mism = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("final_memory", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
